// File: rtl/k7_cpl_tx_pkg.sv
// Shared completion-TLP definitions: field encodings, header layout, FSM states, tkeep helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package k7_cpl_tx_pkg;

    localparam logic [2:0] FMT_3DW_D = 3'b010;
    localparam logic [4:0] TYPE_CPL  = 5'b01010;
    localparam logic [2:0] CPL_SC    = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT,
        ST_TAIL
    } cpl_state_e;

    // dw0 sits in the least significant 32 bits, matching its position on the bus
    typedef struct packed {
        logic [31:0] dw2;
        logic [31:0] dw1;
        logic [31:0] dw0;
    } cpl_hdr_t;

    // Byte enables for a beat carrying n_dw valid DWs, packed from the LSB
    function automatic logic [15:0] keep_from_dw(input logic [2:0] n_dw);
        case (n_dw)
            3'd1:    return 16'h000F;
            3'd2:    return 16'h00FF;
            3'd3:    return 16'h0FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

endpackage

// File: rtl/k7_cpl_tx_hdr.sv
// Builds the 3DW CplD header from a read descriptor and the completer ID.
// Latency: combinational.
// Backpressure: none; the caller registers the result on descriptor accept.
module k7_cpl_hdr
    import k7_cpl_tx_pkg::*;
(
    input  logic [5:0]  len,
    input  logic [2:0]  tc,
    input  logic [1:0]  attr,
    input  logic [15:0] completer_id,
    input  logic [11:0] bcnt,
    input  logic [15:0] rid,
    input  logic [7:0]  tag,
    input  logic [6:0]  laddr,
    output cpl_hdr_t    hdr
);

    // Assemble the three header DWs; TD, EP and BCM are always clear
    always_comb begin
        hdr     = '0;
        hdr.dw0 = {FMT_3DW_D, TYPE_CPL, 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr, 2'b00, {4'b0000, len}};
        hdr.dw1 = {completer_id, CPL_SC, 1'b0, bcnt};
        hdr.dw2 = {rid, tag, 1'b0, laddr};
    end

endmodule

// File: rtl/k7_cpl_tx.sv
// Completion TX engine: descriptor + 128-bit payload stream -> 3DW CplD TLP on s_axis_tx.
// Latency: req fire at N, payload beat at N+1 -> first TLP beat valid at N+2; 1 beat/cycle sustained.
// Backpressure: one output register stalls on s_axis_tx_tready; dat_tready is low while it is full and not draining.
module k7_cpl_tx
    import k7_cpl_tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int C_MAX_DW     = 32,
    parameter int C_TXBUF_MIN  = 2
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic                    user_link_up,
    input  logic [5:0]              tx_buf_av,
    input  logic [15:0]             cfg_completer_id,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [5:0]              req_len,
    input  logic [7:0]              req_tag,
    input  logic [15:0]             req_rid,
    input  logic [2:0]              req_tc,
    input  logic [1:0]              req_attr,
    input  logic [6:0]              req_laddr,
    input  logic [11:0]             req_bcnt,
    input  logic [C_DATA_WIDTH-1:0] dat_tdata,
    input  logic                    dat_tvalid,
    output logic                    dat_tready,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    input  logic                    s_axis_tx_tready,
    output logic [3:0]              s_axis_tx_tuser,
    output logic                    cpl_done
);

    cpl_state_e state_q, state_d;
    cpl_hdr_t   hdr_w;
    logic [95:0] hdr_q;
    logic [95:0] hold_q;          // upper three DWs of the previous payload beat
    logic [5:0]  len_q;
    logic [4:0]  in_left_q;       // payload beats still to be popped
    logic        first_q;         // next payload beat is the one merged with the header

    logic        can_load, link_ok, free, req_fire, dat_fire, last_in, no_tail;
    logic [1:0]  last_dw_mod;
    logic [2:0]  last_dw;
    logic [6:0]  len_p3;
    logic        ld, ld_last;
    logic [C_DATA_WIDTH-1:0] ld_dat;
    logic [KEEP_WIDTH-1:0]   ld_keep;

    assign can_load    = !s_axis_tx_tvalid || s_axis_tx_tready;
    assign link_ok     = user_link_up && (tx_buf_av >= 6'(C_TXBUF_MIN));
    assign last_in     = (in_left_q == 5'd1);
    // len%4==1 fills the last output beat exactly, so no hold-only beat follows
    assign no_tail     = (len_q[1:0] == 2'b01);
    assign last_dw_mod = len_q[1:0] + 2'd3;
    assign last_dw     = (last_dw_mod == 2'd0) ? 3'd4 : {1'b0, last_dw_mod};
    assign len_p3      = {1'b0, req_len} + 7'd3;
    assign req_fire    = req_valid && req_ready;
    assign s_axis_tx_tuser = 4'b0000;

    k7_cpl_hdr u_hdr (
        .len          (req_len),
        .tc           (req_tc),
        .attr         (req_attr),
        .completer_id (cfg_completer_id),
        .bcnt         (req_bcnt),
        .rid          (req_rid),
        .tag          (req_tag),
        .laddr        (req_laddr),
        .hdr          (hdr_w)
    );

    // State register
    always_ff @(posedge user_clk) begin
        if (user_reset) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next state, handshakes and the beat to load; a new descriptor is taken the
    // same cycle the previous TLP's final beat is loaded so TLPs run back-to-back
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        dat_tready = 1'b0;
        free       = 1'b0;
        dat_fire   = 1'b0;
        ld         = 1'b0;
        ld_last    = 1'b0;
        ld_dat     = '0;
        ld_keep    = '0;
        case (state_q)
            ST_IDLE: free = 1'b1;
            ST_BEAT: begin
                dat_tready = can_load;
                if (dat_tvalid && can_load) begin
                    dat_fire = 1'b1;
                    ld       = 1'b1;
                    ld_dat   = {dat_tdata[31:0], first_q ? hdr_q : hold_q};
                    ld_last  = last_in && no_tail;
                    ld_keep  = ld_last ? keep_from_dw(last_dw) : '1;
                    if (last_in) begin
                        state_d = no_tail ? ST_IDLE : ST_TAIL;
                        free    = no_tail;
                    end
                end
            end
            ST_TAIL: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_dat  = {32'h0, hold_q};
                    ld_last = 1'b1;
                    ld_keep = keep_from_dw(last_dw);
                    state_d = ST_IDLE;
                    free    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready = free && link_ok && !user_reset;
        if (user_reset) dat_tready = 1'b0;
        if (req_valid && req_ready) state_d = ST_BEAT;
    end

    // Descriptor capture and payload realignment state
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            hdr_q     <= '0;
            hold_q    <= '0;
            len_q     <= '0;
            in_left_q <= '0;
            first_q   <= 1'b0;
        end else begin
            if (dat_fire) begin
                hold_q    <= dat_tdata[127:32];
                in_left_q <= in_left_q - 5'd1;
                first_q   <= 1'b0;
            end
            if (req_fire) begin
                hdr_q     <= hdr_w;
                len_q     <= req_len;
                in_left_q <= len_p3[6:2];
                first_q   <= 1'b1;
            end
        end
    end

    // Output register: holds a beat until the core accepts it; cpl_done follows the last accept
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
            cpl_done         <= 1'b0;
        end else begin
            cpl_done <= s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;
            if (ld) begin
                s_axis_tx_tvalid <= 1'b1;
                s_axis_tx_tdata  <= ld_dat;
                s_axis_tx_tkeep  <= ld_keep;
                s_axis_tx_tlast  <= ld_last;
            end else if (s_axis_tx_tready) begin
                s_axis_tx_tvalid <= 1'b0;
            end
        end
    end

    // Descriptor lengths outside 1..C_MAX_DW have no defined framing
    assert property (@(posedge user_clk) disable iff (user_reset)
        req_fire |-> (req_len != 6'd0 && int'(req_len) <= C_MAX_DW));

endmodule

// File: tb/tb_k7_cpl_tx.sv
// Self-checking bench for k7_cpl_tx: reference TLP model feeds a scoreboard of expected beats.
// Latency: n/a.
// Backpressure: random sink ready and random payload gaps under per-test knobs.
module tb_k7_cpl_tx;

    logic         user_clk = 1'b0;
    logic         user_reset, user_link_up;
    logic [5:0]   tx_buf_av;
    logic [15:0]  cfg_completer_id;
    logic         req_valid, req_ready;
    logic [5:0]   req_len;
    logic [7:0]   req_tag;
    logic [15:0]  req_rid;
    logic [2:0]   req_tc;
    logic [1:0]   req_attr;
    logic [6:0]   req_laddr;
    logic [11:0]  req_bcnt;
    logic [127:0] dat_tdata;
    logic         dat_tvalid, dat_tready;
    logic [127:0] s_axis_tx_tdata;
    logic [15:0]  s_axis_tx_tkeep;
    logic         s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
    logic [3:0]   s_axis_tx_tuser;
    logic         cpl_done;

    typedef struct packed {
        logic [127:0] dat;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] din_q[$];
    int           fire_cyc_q[$];
    int n_vec = 0, n_err = 0;
    int beats_seen = 0, tlps_seen = 0, done_seen = 0, dat_pops = 0, cyc = 0;
    int dat_gap = 0, rdy_pct = 100;
    beat_t last_beat;
    beat_t held;
    bit    stall_pend = 1'b0;

    always #5 user_clk = ~user_clk;
    always @(posedge user_clk) cyc <= cyc + 1;

    k7_cpl_tx dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .user_link_up     (user_link_up),
        .tx_buf_av        (tx_buf_av),
        .cfg_completer_id (cfg_completer_id),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_len          (req_len),
        .req_tag          (req_tag),
        .req_rid          (req_rid),
        .req_tc           (req_tc),
        .req_attr         (req_attr),
        .req_laddr        (req_laddr),
        .req_bcnt         (req_bcnt),
        .dat_tdata        (dat_tdata),
        .dat_tvalid       (dat_tvalid),
        .dat_tready       (dat_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .cpl_done         (cpl_done)
    );

    // Sink: random ready per cycle
    initial begin
        s_axis_tx_tready = 1'b0;
        forever begin
            @(posedge user_clk); #1;
            s_axis_tx_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Payload source: offers din_q head, holds it until accepted, random gaps otherwise
    initial begin
        bit dfire;
        dat_tvalid = 1'b0;
        dat_tdata  = '0;
        forever begin
            @(negedge user_clk);
            dfire = dat_tvalid && dat_tready;
            @(posedge user_clk); #1;
            if (dfire && din_q.size() != 0) void'(din_q.pop_front());
            if (din_q.size() == 0) dat_tvalid = 1'b0;
            else if (dat_tvalid && !dfire) dat_tvalid = 1'b1;
            else if ($urandom_range(99) >= dat_gap) begin
                dat_tvalid = 1'b1;
                dat_tdata  = din_q[0];
            end else dat_tvalid = 1'b0;
        end
    end

    // Output monitor: scoreboard pop on each accepted beat, stability check while stalled
    always @(negedge user_clk) begin
        beat_t cur, e;
        logic [127:0] m;
        if (user_reset) begin
            stall_pend = 1'b0;
        end else begin
            cur = '{dat: s_axis_tx_tdata, keep: s_axis_tx_tkeep, last: s_axis_tx_tlast};
            if (stall_pend && s_axis_tx_tvalid) begin
                n_vec++;
                if (cur !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h/%h/%b need %h/%h/%b", cur.dat, cur.keep, cur.last, held.dat, held.keep, held.last);
                end
            end
            stall_pend = s_axis_tx_tvalid && !s_axis_tx_tready;
            held       = cur;
            if (dat_tvalid && dat_tready) dat_pops++;
            if (cpl_done) done_seen++;
            if (s_axis_tx_tvalid && s_axis_tx_tready) begin
                fire_cyc_q.push_back(cyc);
                beats_seen++;
                last_beat = cur;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %h keep %h, need no beat", cur.dat, cur.keep);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{e.keep[i]}};
                    if ((cur.dat & m) !== (e.dat & m) || cur.keep !== e.keep || cur.last !== e.last) begin
                        n_err++;
                        $display("FAIL beat: got %h k=%h l=%b need %h k=%h l=%b", cur.dat, cur.keep, cur.last, e.dat, e.keep, e.last);
                    end
                end
                if (s_axis_tx_tlast) tlps_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    // Push expected beats and payload beats, then present the descriptor until accepted
    task automatic send_req(input int len, input logic [7:0] tag, input logic [15:0] rid,
                            input logic [2:0] tc, input logic [1:0] attr, input logic [6:0] laddr,
                            input logic [11:0] bcnt, input logic [31:0] base);
        logic [31:0]  dws[$];
        logic [127:0] ib;
        beat_t        b;
        int           nb, idx, k;
        bit           fired;
        dws.push_back(32'h4A000000 | (32'(tc) << 20) | (32'(attr) << 12) | 32'(len));
        dws.push_back((32'(cfg_completer_id) << 16) | 32'(bcnt));
        dws.push_back((32'(rid) << 16) | (32'(tag) << 8) | 32'(laddr));
        for (int i = 0; i < len; i++) dws.push_back(base + 32'(i));
        nb = (dws.size() + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * bi + j;
                if (idx < dws.size()) begin
                    b.dat[32*j +: 32] = dws[idx];
                    b.keep[4*j +: 4]  = 4'hF;
                end
            end
            b.last = (bi == nb - 1);
            exp_q.push_back(b);
        end
        for (int bi = 0; bi < (len + 3) / 4; bi++) begin
            ib = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * bi + j;
                if (idx < len) ib[32*j +: 32] = base + 32'(idx);
            end
            din_q.push_back(ib);
        end
        @(posedge user_clk); #1;
        req_valid = 1'b1; req_len = 6'(len); req_tag = tag; req_rid = rid;
        req_tc = tc; req_attr = attr; req_laddr = laddr; req_bcnt = bcnt;
        fired = 1'b0;
        k = 0;
        while (!fired && k < 2000) begin
            @(negedge user_clk);
            if (req_ready) fired = 1'b1;
            k++;
        end
        @(posedge user_clk); #1;
        req_valid = 1'b0;
        if (!fired) begin
            n_vec++; n_err++;
            $display("FAIL req_accept: req_ready never seen for len %0d, need accept", len);
            exp_q.delete(); din_q.delete();
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || din_q.size() != 0) && k < 3000) begin
            @(negedge user_clk);
            k++;
        end
        repeat (3) @(negedge user_clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, need 0", name, exp_q.size());
            exp_q.delete(); din_q.delete();
        end
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        n_vec++; if (req_ready !== 1'b0)        begin n_err++; $display("FAIL rst_req_ready: got %b need 0", req_ready); end
        n_vec++; if (dat_tready !== 1'b0)       begin n_err++; $display("FAIL rst_dat_tready: got %b need 0", dat_tready); end
        n_vec++; if (s_axis_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b need 0", s_axis_tx_tvalid); end
        n_vec++; if (s_axis_tx_tlast !== 1'b0)  begin n_err++; $display("FAIL rst_tlast: got %b need 0", s_axis_tx_tlast); end
        n_vec++; if (s_axis_tx_tkeep !== 16'h0) begin n_err++; $display("FAIL rst_tkeep: got %h need 0", s_axis_tx_tkeep); end
        n_vec++; if (s_axis_tx_tdata !== 128'h0) begin n_err++; $display("FAIL rst_tdata: got %h need 0", s_axis_tx_tdata); end
        n_vec++; if (cpl_done !== 1'b0)         begin n_err++; $display("FAIL rst_cpl_done: got %b need 0", cpl_done); end
        n_vec++; if (s_axis_tx_tuser !== 4'h0)  begin n_err++; $display("FAIL rst_tuser: got %h need 0", s_axis_tx_tuser); end
        @(posedge user_clk); #1;
        user_reset = 1'b0;
    endtask

    task automatic test_single();
        int b0 = beats_seen, d0 = done_seen;
        send_req(1, 8'h5A, 16'h0100, 3'd0, 2'd0, 7'h04, 12'd4, 32'hDEADBEEF);
        wait_drain("single");
        n_vec++; if (beats_seen - b0 != 1)            begin n_err++; $display("FAIL single_beats: got %0d need 1", beats_seen - b0); end
        n_vec++; if (last_beat.last !== 1'b1)         begin n_err++; $display("FAIL single_tlast: got %b need 1", last_beat.last); end
        n_vec++; if (last_beat.keep !== 16'hFFFF)     begin n_err++; $display("FAIL single_tkeep: got %h need FFFF", last_beat.keep); end
        n_vec++; if (last_beat.dat[127:96] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h need DEADBEEF", last_beat.dat[127:96]); end
        n_vec++; if (last_beat.dat[31:0] !== 32'h4A000001)   begin n_err++; $display("FAIL single_dw0: got %h need 4A000001", last_beat.dat[31:0]); end
        n_vec++; if (last_beat.dat[63:32] !== 32'h03000004)  begin n_err++; $display("FAIL single_dw1: got %h need 03000004", last_beat.dat[63:32]); end
        n_vec++; if (last_beat.dat[95:64] !== 32'h01005A04)  begin n_err++; $display("FAIL single_dw2: got %h need 01005A04", last_beat.dat[95:64]); end
        n_vec++; if (done_seen - d0 != 1)             begin n_err++; $display("FAIL single_cpl_done: got %0d pulses need 1", done_seen - d0); end
    endtask

    task automatic test_tail();
        int b0 = beats_seen, p0 = dat_pops;
        send_req(4, 8'h11, 16'h0200, 3'd5, 2'b10, 7'h00, 12'd16, 32'h0);
        wait_drain("tail");
        n_vec++; if (beats_seen - b0 != 2)            begin n_err++; $display("FAIL tail_beats: got %0d need 2", beats_seen - b0); end
        n_vec++; if (last_beat.keep !== 16'h0FFF)     begin n_err++; $display("FAIL tail_tkeep: got %h need 0FFF", last_beat.keep); end
        n_vec++; if (last_beat.dat[95:0] !== {32'd3, 32'd2, 32'd1}) begin n_err++; $display("FAIL tail_data: got %h need 000000030000000200000001", last_beat.dat[95:0]); end
        n_vec++; if (dat_pops - p0 != 1)              begin n_err++; $display("FAIL tail_pops: got %0d need 1", dat_pops - p0); end
    endtask

    task automatic test_back_to_back();
        int t0 = tlps_seen, span;
        rdy_pct = 100; dat_gap = 0;
        fire_cyc_q.delete();
        send_req(32, 8'h20, 16'h0300, 3'd1, 2'b01, 7'h40, 12'd128, 32'h1000);
        send_req(32, 8'h21, 16'h0300, 3'd2, 2'b00, 7'h00, 12'd128, 32'h2000);
        wait_drain("b2b");
        span = (fire_cyc_q.size() > 0) ? fire_cyc_q[fire_cyc_q.size() - 1] - fire_cyc_q[0] : -1;
        n_vec++; if (fire_cyc_q.size() != 18) begin n_err++; $display("FAIL b2b_beats: got %0d need 18", fire_cyc_q.size()); end
        n_vec++; if (span != 17)              begin n_err++; $display("FAIL b2b_gapless: span %0d cycles need 17", span); end
        n_vec++; if (tlps_seen - t0 != 2)     begin n_err++; $display("FAIL b2b_tlps: got %0d need 2", tlps_seen - t0); end
    endtask

    task automatic test_stall();
        int t0 = tlps_seen;
        rdy_pct = 50; dat_gap = 40;
        for (int i = 0; i < 3; i++)
            send_req(8, 8'(8'h30 + i), 16'h0400, 3'(i), 2'(i), 7'(i * 8), 12'd32, $urandom);
        wait_drain("stall");
        n_vec++; if (tlps_seen - t0 != 3) begin n_err++; $display("FAIL stall_tlps: got %0d need 3", tlps_seen - t0); end
        rdy_pct = 100; dat_gap = 0;
    endtask

    task automatic test_gating();
        int t0, k, b0;
        tx_buf_av = 6'd1;
        fork
            send_req(2, 8'h40, 16'h0500, 3'd0, 2'd0, 7'h10, 12'd8, 32'hA0);
            begin
                repeat (4) begin
                    @(negedge user_clk);
                    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL txbuf_gate: got %b need 0", req_ready); end
                end
                @(posedge user_clk); #1; tx_buf_av = 6'd2;
                @(negedge user_clk);
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL txbuf_open: got %b need 1", req_ready); end
            end
        join
        wait_drain("txbuf");
        tx_buf_av = 6'd10;
        user_link_up = 1'b0;
        fork
            send_req(3, 8'h41, 16'h0500, 3'd0, 2'd0, 7'h20, 12'd12, 32'hB0);
            begin
                repeat (4) begin
                    @(negedge user_clk);
                    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL link_gate: got %b need 0", req_ready); end
                end
                @(posedge user_clk); #1; user_link_up = 1'b1;
            end
        join
        wait_drain("link");
        // Link drop after the TLP has started must not truncate it
        t0 = tlps_seen; b0 = beats_seen;
        send_req(16, 8'h42, 16'h0500, 3'd0, 2'd0, 7'h00, 12'd64, 32'hC0);
        k = 0;
        while (beats_seen == b0 && k < 200) begin @(negedge user_clk); k++; end
        @(posedge user_clk); #1; user_link_up = 1'b0;
        wait_drain("linkdrop");
        n_vec++; if (tlps_seen - t0 != 1) begin n_err++; $display("FAIL linkdrop_tlps: got %0d need 1", tlps_seen - t0); end
        user_link_up = 1'b1;
    endtask

    task automatic test_reset_mid();
        int b0, d0, t0, k;
        rdy_pct = 100; dat_gap = 0;
        b0 = beats_seen; d0 = done_seen;
        send_req(16, 8'h50, 16'h0600, 3'd0, 2'd0, 7'h00, 12'd64, 32'hE000);
        k = 0;
        while (beats_seen - b0 < 3 && k < 200) begin @(negedge user_clk); k++; end
        n_vec++; if (beats_seen - b0 < 3) begin n_err++; $display("FAIL rstmid_start: got %0d beats need 3", beats_seen - b0); end
        @(posedge user_clk); #1;
        user_reset = 1'b1;
        exp_q.delete(); din_q.delete();
        @(posedge user_clk);
        @(negedge user_clk);
        n_vec++; if (s_axis_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid: got %b need 0", s_axis_tx_tvalid); end
        n_vec++; if (s_axis_tx_tkeep !== 16'h0)  begin n_err++; $display("FAIL rstmid_tkeep: got %h need 0", s_axis_tx_tkeep); end
        n_vec++; if (s_axis_tx_tlast !== 1'b0)   begin n_err++; $display("FAIL rstmid_tlast: got %b need 0", s_axis_tx_tlast); end
        @(posedge user_clk); #1;
        user_reset = 1'b0;
        n_vec++; if (done_seen - d0 != 0) begin n_err++; $display("FAIL rstmid_done: got %0d pulses need 0", done_seen - d0); end
        b0 = beats_seen; d0 = done_seen; t0 = tlps_seen;
        send_req(2, 8'h51, 16'h0600, 3'd0, 2'd0, 7'h08, 12'd8, 32'hF00D0000);
        wait_drain("rstmid");
        n_vec++; if (beats_seen - b0 != 2) begin n_err++; $display("FAIL rstmid_beats: got %0d need 2", beats_seen - b0); end
        n_vec++; if (tlps_seen - t0 != 1)  begin n_err++; $display("FAIL rstmid_tlps: got %0d need 1", tlps_seen - t0); end
        n_vec++; if (done_seen - d0 != 1)  begin n_err++; $display("FAIL rstmid_cpl_done: got %0d need 1", done_seen - d0); end
    endtask

    initial begin
        user_reset = 1'b1; user_link_up = 1'b1; tx_buf_av = 6'd10;
        cfg_completer_id = 16'h0300;
        req_valid = 1'b0; req_len = 6'd1; req_tag = '0; req_rid = '0;
        req_tc = '0; req_attr = '0; req_laddr = '0; req_bcnt = '0;
        test_reset();
        test_single();
        test_tail();
        test_back_to_back();
        test_stall();
        test_gating();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
